// File: rtl/fetch_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_if
//
// Instruction cache read port shared between the fetch stage and the cache.
//
// Signals:
//   rd_addr  fetch -> cache   32  word-aligned read address
//   rd_req   fetch -> cache    1  read request
//   rd_wait  cache -> fetch    1  read not complete this cycle
//   rd_data  cache -> fetch   32  read data, valid when rd_req && !rd_wait
//
// Modports:
//   master  the fetch stage (drives address/request)
//   slave   the instruction cache (drives wait/data)
// ---------------------------------------------------------------------------
interface fetch_queue_if;
    logic [31:0] rd_addr;
    logic        rd_req;
    logic        rd_wait;
    logic [31:0] rd_data;

    modport master (
        output rd_addr,
        output rd_req,
        input  rd_wait,
        input  rd_data
    );

    modport slave (
        input  rd_addr,
        input  rd_req,
        output rd_wait,
        output rd_data
    );
endinterface

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch stage sitting directly in front of decode. Owns the fetch
// PC, issues one word read per cycle to the instruction cache and buffers the
// returned instructions in a small FIFO so decode stalls and cache wait states
// do not lose or duplicate work. Branch/exception redirects flush everything
// younger and restart fetch at the new target.
//
// Parameters:
//   RESET_PC  fetch address loaded on reset
//   QDEPTH    instruction queue entries (power of two, >= 2)
//
// Ports:
//   clk     in   1   clock
//   rst     in   1   synchronous active-high reset
//   ic      master   instruction cache read port (see fetch_queue_if)
//   stall   in   1   decode cannot accept; hold outputs
//   jmp     in   1   redirect fetch; flush everything younger
//   jmppc   in  32   redirect target (low two bits ignored)
//   bubble  out  1   insn/pc not valid this cycle
//   insn    out 32   instruction to decode
//   pc      out 32   address of insn
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_queue_if.master        ic,
    input  logic                 stall,
    input  logic                 jmp,
    input  logic [31:0]          jmppc,
    output logic                 bubble,
    output logic [31:0]          insn,
    output logic [31:0]          pc
);

    // Pointers carry one extra wrap bit so full and empty can be told apart
    // when the index bits match.
    localparam int AW = $clog2(QDEPTH);
    localparam int PW = AW + 1;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    logic [31:0]   reqpc;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   q_insn [QDEPTH];
    logic [31:0]   q_pc   [QDEPTH];

    logic empty;
    logic full;
    logic pop;
    logic fetch_done;
    logic bypass;
    logic push;

    // Queue status from the pointer pair: equal pointers mean empty, equal
    // index with differing wrap bits means every slot is occupied.
    assign empty = (head == tail);
    assign full  = (head[AW] != tail[AW]) && (head[AW-1:0] == tail[AW-1:0]);

    // Decode consumes the head whenever it is not stalled; reset and redirect
    // discard the queue instead of draining it.
    assign pop = !rst && !jmp && !stall && !empty;

    // A read is only issued when its result is guaranteed a home: either a
    // free slot exists or the head leaves this same cycle. Redirect and reset
    // cycles never request, so no stale data can be accepted there.
    assign ic.rd_req  = !rst && !jmp && (!full || pop);
    assign ic.rd_addr = reqpc;

    assign fetch_done = ic.rd_req && !ic.rd_wait;

    // With nothing queued and decode ready, the returning word skips the
    // queue and lands in the output register directly (1-cycle latency).
    assign bypass = fetch_done && !stall && empty;
    assign push   = fetch_done && !bypass;

    // Fetch PC: reset and redirect load a word-aligned target, otherwise the
    // PC advances only when the cache actually delivers the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            reqpc <= RESET_PC & WORD_MASK;
        end else if (jmp) begin
            reqpc <= jmppc & WORD_MASK;
        end else if (fetch_done) begin
            reqpc <= reqpc + 32'd4;
        end
    end

    // Queue pointers: a redirect empties the queue by resetting both
    // pointers, since nothing older than the branch may survive it.
    always_ff @(posedge clk) begin
        if (rst || jmp) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
        end
    end

    // Queue storage holds the instruction together with the PC it came from.
    // When full, a push only happens alongside a pop, so writing the tail slot
    // (same index as the head) is safe: the head is read out this cycle.
    always_ff @(posedge clk) begin
        if (push) begin
            q_insn[tail[AW-1:0]] <= ic.rd_data;
            q_pc[tail[AW-1:0]]   <= reqpc;
        end
    end

    // Output register toward decode. Priority: reset, redirect, stall hold,
    // queued head, bypassed fresh read, then bubble. insn/pc keep their last
    // value whenever bubble is raised outside reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble <= 1'b1;
            insn   <= 32'h0;
            pc     <= 32'h0;
        end else if (jmp) begin
            bubble <= 1'b1;
        end else if (!stall) begin
            if (pop) begin
                bubble <= 1'b0;
                insn   <= q_insn[head[AW-1:0]];
                pc     <= q_pc[head[AW-1:0]];
            end else if (bypass) begin
                bubble <= 1'b0;
                insn   <= ic.rd_data;
                pc     <= reqpc;
            end else begin
                bubble <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Self-checking bench for fetch_queue. The bench plays the instruction cache
// (data = address ^ 32'hE000_0000) and keeps its own model of the fetch
// address and of the in-flight instruction stream as a scoreboard queue.
// Scenario tasks add directed checks for each behaviour of interest.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QDEPTH   = 2;
    localparam logic [31:0] DMASK    = 32'hE000_0000;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        stall = 1'b0;
    logic        jmp   = 1'b0;
    logic [31:0] jmppc = 32'h0;
    logic        bubble;
    logic [31:0] insn;
    logic [31:0] pc;

    int checks = 0;
    int errors = 0;

    fetch_queue_if ic();

    fetch_queue #(
        .RESET_PC (RESET_PC),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ic     (ic),
        .stall  (stall),
        .jmp    (jmp),
        .jmppc  (jmppc),
        .bubble (bubble),
        .insn   (insn),
        .pc     (pc)
    );

    always #5 clk = ~clk;

    // The cache model returns a word derived from the address it was given.
    assign ic.rd_data = ic.rd_addr ^ DMASK;

    // Scoreboard model state: expected fetch address, instructions fetched but
    // not yet delivered ({insn, pc}), and the expected output register.
    logic [63:0] sb [$];
    logic [63:0] item;
    logic [31:0] exp_addr = 32'h0;
    logic        e_bubble = 1'b1;
    logic [31:0] e_insn   = 32'h0;
    logic [31:0] e_pc     = 32'h0;
    logic        exp_req;
    logic        fire;
    bit          have_exp = 1'b0;
    bit          synced   = 1'b0;

    // Monitor on the falling edge: first compare the outputs produced by the
    // previous rising edge, then check the cache port and predict the next
    // edge from the inputs currently applied.
    always @(negedge clk) begin
        if (have_exp) begin
            checks++;
            if (bubble !== e_bubble) begin
                errors++;
                $display("[TB] FAIL sb_bubble got %0b want %0b t=%0t", bubble, e_bubble, $time);
            end
            checks++;
            if (insn !== e_insn) begin
                errors++;
                $display("[TB] FAIL sb_insn got %h want %h t=%0t", insn, e_insn, $time);
            end
            checks++;
            if (pc !== e_pc) begin
                errors++;
                $display("[TB] FAIL sb_pc got %h want %h t=%0t", pc, e_pc, $time);
            end
        end
        exp_req = !rst && !jmp && ((sb.size() < QDEPTH) || (!stall && sb.size() > 0));
        if (synced) begin
            checks++;
            if (ic.rd_addr !== exp_addr) begin
                errors++;
                $display("[TB] FAIL sb_addr got %h want %h t=%0t", ic.rd_addr, exp_addr, $time);
            end
            checks++;
            if (ic.rd_req !== exp_req) begin
                errors++;
                $display("[TB] FAIL sb_req got %0b want %0b t=%0t", ic.rd_req, exp_req, $time);
            end
            checks++;
            if (!rst && dut.push && dut.full && !dut.pop) begin
                errors++;
                $display("[TB] FAIL push_full got push into full queue t=%0t want none", $time);
            end
        end
        fire = exp_req && !ic.rd_wait;
        if (rst) begin
            sb.delete();
            exp_addr = RESET_PC & 32'hFFFF_FFFC;
            e_bubble = 1'b1;
            e_insn   = 32'h0;
            e_pc     = 32'h0;
            synced   = 1'b1;
            have_exp = 1'b1;
        end else if (synced) begin
            if (jmp) begin
                sb.delete();
                exp_addr = jmppc & 32'hFFFF_FFFC;
                e_bubble = 1'b1;
            end else begin
                if (fire) begin
                    sb.push_back({exp_addr ^ DMASK, exp_addr});
                    exp_addr = exp_addr + 32'd4;
                end
                if (!stall) begin
                    if (sb.size() > 0) begin
                        item     = sb.pop_front();
                        e_insn   = item[63:32];
                        e_pc     = item[31:0];
                        e_bubble = 1'b0;
                    end else begin
                        e_bubble = 1'b1;
                    end
                end
            end
            checks++;
            if (sb.size() > QDEPTH) begin
                errors++;
                $display("[TB] FAIL sb_occupancy got %0d want <= %0d", sb.size(), QDEPTH);
            end
        end
    end

    // Advance one clock; inputs change and directed samples are taken 1 time
    // unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        stall      = 1'b0;
        jmp        = 1'b0;
        jmppc      = 32'h0;
        ic.rd_wait = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reset values and that reset keeps the request low.
    task automatic test_reset();
        rst        = 1'b1;
        ic.rd_wait = 1'b0;
        tick();
        tick();
        checks++;
        if (bubble !== 1'b1) begin errors++; $display("[TB] FAIL reset_bubble got %0b want 1", bubble); end
        checks++;
        if (insn !== 32'h0) begin errors++; $display("[TB] FAIL reset_insn got %h want 0", insn); end
        checks++;
        if (pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc got %h want 0", pc); end
        checks++;
        if (ic.rd_addr !== RESET_PC) begin errors++; $display("[TB] FAIL reset_addr got %h want %h", ic.rd_addr, RESET_PC); end
        checks++;
        if (ic.rd_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %0b want 0", ic.rd_req); end
        rst = 1'b0;
    endtask

    // Free-running fetch: one instruction per cycle, first one right after reset.
    task automatic test_stream();
        logic [31:0] want;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick();
            want = 32'(i * 4);
            checks++;
            if (bubble !== 1'b0) begin errors++; $display("[TB] FAIL stream_bubble got %0b want 0 i=%0d", bubble, i); end
            checks++;
            if (pc !== want) begin errors++; $display("[TB] FAIL stream_pc got %h want %h", pc, want); end
            checks++;
            if (insn !== (want ^ DMASK)) begin errors++; $display("[TB] FAIL stream_insn got %h want %h", insn, want ^ DMASK); end
            checks++;
            if (ic.rd_addr !== want + 32'd4) begin errors++; $display("[TB] FAIL stream_addr got %h want %h", ic.rd_addr, want + 32'd4); end
        end
    endtask

    // Cache wait states hold the address and produce bubbles.
    task automatic test_wait();
        do_reset();
        tick();
        tick();
        checks++;
        if (ic.rd_addr !== 32'h8) begin errors++; $display("[TB] FAIL wait_addr0 got %h want 8", ic.rd_addr); end
        ic.rd_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ic.rd_addr !== 32'h8) begin errors++; $display("[TB] FAIL wait_addr got %h want 8", ic.rd_addr); end
            checks++;
            if (ic.rd_req !== 1'b1) begin errors++; $display("[TB] FAIL wait_req got %0b want 1", ic.rd_req); end
            checks++;
            if (bubble !== 1'b1) begin errors++; $display("[TB] FAIL wait_bubble got %0b want 1", bubble); end
            checks++;
            if (pc !== 32'h4) begin errors++; $display("[TB] FAIL wait_pc_hold got %h want 4", pc); end
        end
        ic.rd_wait = 1'b0;
        tick();
        checks++;
        if (bubble !== 1'b0 || pc !== 32'h8) begin errors++; $display("[TB] FAIL wait_resume got bubble=%0b pc=%h want 0/8", bubble, pc); end
        tick();
        checks++;
        if (bubble !== 1'b0 || pc !== 32'hC) begin errors++; $display("[TB] FAIL wait_next got bubble=%0b pc=%h want 0/c", bubble, pc); end
    endtask

    // Decode stall fills the queue, throttles the cache, then drains in order.
    task automatic test_stall();
        logic [31:0] want;
        do_reset();
        tick();
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (bubble !== 1'b0 || pc !== 32'h0) begin errors++; $display("[TB] FAIL stall_hold got bubble=%0b pc=%h want 0/0", bubble, pc); end
            if (k >= 1) begin
                checks++;
                if (ic.rd_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req got %0b want 0 k=%0d", ic.rd_req, k); end
            end
        end
        stall = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            tick();
            want = 32'(j * 4);
            checks++;
            if (bubble !== 1'b0 || pc !== want) begin errors++; $display("[TB] FAIL stall_drain got bubble=%0b pc=%h want 0/%h", bubble, pc, want); end
        end
    endtask

    // Redirect with a full queue and decode stalled flushes everything.
    task automatic test_jmp_flush();
        do_reset();
        tick();
        stall = 1'b1;
        tick();
        tick();
        jmp   = 1'b1;
        jmppc = 32'h0000_0103;
        #1;
        checks++;
        if (ic.rd_req !== 1'b0) begin errors++; $display("[TB] FAIL jmp_req got %0b want 0", ic.rd_req); end
        tick();
        jmp = 1'b0;
        #1;
        checks++;
        if (bubble !== 1'b1) begin errors++; $display("[TB] FAIL jmp_bubble got %0b want 1", bubble); end
        checks++;
        if (ic.rd_addr !== 32'h100) begin errors++; $display("[TB] FAIL jmp_addr got %h want 100", ic.rd_addr); end
        checks++;
        if (pc !== 32'h0) begin errors++; $display("[TB] FAIL jmp_pc_hold got %h want 0", pc); end
        checks++;
        if (ic.rd_req !== 1'b1) begin errors++; $display("[TB] FAIL jmp_req_after got %0b want 1", ic.rd_req); end
        stall = 1'b0;
        tick();
        checks++;
        if (bubble !== 1'b0 || pc !== 32'h100) begin errors++; $display("[TB] FAIL jmp_target got bubble=%0b pc=%h want 0/100", bubble, pc); end
        tick();
        checks++;
        if (bubble !== 1'b0 || pc !== 32'h104) begin errors++; $display("[TB] FAIL jmp_next got bubble=%0b pc=%h want 0/104", bubble, pc); end
    endtask

    // Redirect in the cycle a read of 0x20 would complete: 0x20 is dropped.
    task automatic test_jmp_read();
        do_reset();
        repeat (8) tick();
        checks++;
        if (ic.rd_addr !== 32'h20) begin errors++; $display("[TB] FAIL jrd_addr got %h want 20", ic.rd_addr); end
        jmp   = 1'b1;
        jmppc = 32'h40;
        #1;
        checks++;
        if (ic.rd_req !== 1'b0) begin errors++; $display("[TB] FAIL jrd_req got %0b want 0", ic.rd_req); end
        tick();
        jmp = 1'b0;
        checks++;
        if (bubble !== 1'b1 || ic.rd_addr !== 32'h40) begin errors++; $display("[TB] FAIL jrd_after got bubble=%0b addr=%h want 1/40", bubble, ic.rd_addr); end
        tick();
        checks++;
        if (bubble !== 1'b0 || pc !== 32'h40 || insn !== (32'h40 ^ DMASK)) begin
            errors++; $display("[TB] FAIL jrd_target got bubble=%0b pc=%h insn=%h want 0/40/%h", bubble, pc, insn, 32'h40 ^ DMASK);
        end
    endtask

    // Reset during a cache wait abandons the read and restarts at RESET_PC.
    task automatic test_reset_mid_wait();
        do_reset();
        repeat (12) tick();
        checks++;
        if (ic.rd_addr !== 32'h30) begin errors++; $display("[TB] FAIL rmw_addr0 got %h want 30", ic.rd_addr); end
        ic.rd_wait = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        ic.rd_wait = 1'b0;
        checks++;
        if (ic.rd_addr !== RESET_PC) begin errors++; $display("[TB] FAIL rmw_addr got %h want %h", ic.rd_addr, RESET_PC); end
        checks++;
        if (bubble !== 1'b1 || pc !== 32'h0 || insn !== 32'h0) begin errors++; $display("[TB] FAIL rmw_out got bubble=%0b pc=%h insn=%h want 1/0/0", bubble, pc, insn); end
        tick();
        checks++;
        if (bubble !== 1'b0 || pc !== RESET_PC) begin errors++; $display("[TB] FAIL rmw_restart got bubble=%0b pc=%h want 0/%h", bubble, pc, RESET_PC); end
        tick();
        checks++;
        if (bubble !== 1'b0 || pc !== RESET_PC + 32'd4) begin errors++; $display("[TB] FAIL rmw_next got bubble=%0b pc=%h want 0/%h", bubble, pc, RESET_PC + 32'd4); end
    endtask

    // Random mix of stalls, wait states and redirects, checked by the scoreboard.
    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            stall      = ($urandom_range(0, 9) < 3);
            ic.rd_wait = ($urandom_range(0, 9) < 3);
            jmp        = ($urandom_range(0, 19) == 0);
            jmppc      = 32'($urandom_range(0, 4095));
            tick();
            checks++;
            if (ic.rd_addr[1:0] !== 2'b00) begin errors++; $display("[TB] FAIL b2b_align got %h want word aligned", ic.rd_addr); end
        end
        stall      = 1'b0;
        ic.rd_wait = 1'b0;
        jmp        = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        ic.rd_wait = 1'b0;
        test_reset();
        test_stream();
        test_wait();
        test_stall();
        test_jmp_flush();
        test_jmp_read();
        test_reset_mid_wait();
        test_back_to_back();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
